// File: rtl/quadrature_generator.sv
// Quadrature (A/B) step generator: emits a programmable number of Gray-coded
// phase edges at a fixed CLK-cycle spacing, or runs continuously until stopped.
module quadrature_generator #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  steps,
  input  logic                stop,
  output logic                signalA,
  output logic                signalB,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  edge_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state_q,  state_d;
  logic                dir_q,    dir_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  steps_q,  steps_d;
  logic [PERIOD_W-1:0] timer_q,  timer_d;
  logic [COUNT_W-1:0]  cnt_q,    cnt_d;
  logic                a_q, a_d, b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    period_d = period_q;
    steps_d  = steps_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d    = dir;
          period_d = period_eff;
          steps_d  = steps;
          cnt_d    = '0;
          timer_d  = period_eff;
          state_d  = RUN;
        end
      end
      default: begin
        // stop outranks both completion and a coinciding timer expiry
        if (stop) begin
          state_d = IDLE;
        end else if (steps_q != '0 && cnt_q == steps_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_q <= PERIOD_W'(1)) begin
          // CW toggles A when A==B else B; CCW is the mirror image
          if ((a_q == b_q) ^ dir_q) a_d = ~a_q;
          else                      b_d = ~b_q;
          cnt_d   = cnt_q + COUNT_W'(1);
          timer_d = period_q;
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      period_q <= '0;
      steps_q  <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign signalA  = a_q;
  assign signalB  = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign edge_cnt = cnt_q;

endmodule

// File: doc/quadrature_generator.md
QUADRATURE_GENERATOR -- requirements
Module: quadrature_generator

Interface
REQ-001 The block SHALL have the following parameters:
- PERIOD_W, default 16, width of the quarter-step period input.
- COUNT_W, default 16, width of the step request and edge counter.

REQ-002 The block SHALL have the following ports (the block has one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- dir  in  1  direction: 0 = clockwise (right), 1 = counter-clockwise (left).
- period  in  PERIOD_W  CLK cycles per quadrature edge; 0 is treated as 1.
- steps  in  COUNT_W  number of quadrature edges to emit; 0 = continuous.
- stop  in  1  abort request, effective in RUN only.
- signalA  out  1  quadrature channel A.
- signalB  out  1  quadrature channel B.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle completion pulse.
- edge_cnt  out  COUNT_W  edges emitted since the last accepted start.

Function
REQ-003 Outputs SHALL be registered, with no combinational path from any input to any output.
REQ-004 The FSM SHALL have exactly two states, IDLE and RUN; the reset state SHALL be IDLE.
REQ-005 In IDLE with start=1, the block SHALL latch dir, period and steps, clear edge_cnt, load the timer, and enter RUN next cycle with busy=1.
REQ-006 start SHALL be ignored while in RUN, and dir/period/steps changes during RUN SHALL have no effect.
REQ-007 In RUN, the timer SHALL count latched period cycles, then advance the phase by one step and reload; the first edge SHALL appear on signalA/signalB exactly period cycles after the start-accept edge.
REQ-008 The clockwise phase sequence (A,B) SHALL be 00->10->11->01->00, so B=0 at every rising edge of A.
REQ-009 The counter-clockwise phase sequence (A,B) SHALL be 00->01->11->10->00, so B=1 at every rising edge of A.
REQ-010 Exactly one of signalA/signalB SHALL change per edge, with no glitches, and both SHALL change only on a timer expiry.
REQ-011 edge_cnt SHALL increment by 1 in the same cycle as each phase change and SHALL wrap modulo 2^COUNT_W in continuous mode.
REQ-012 With steps≠0, when edge_cnt reaches steps, the block SHALL return to IDLE: busy=0 and done=1 for one cycle, both in the cycle after the final edge; no further edges SHALL occur.
REQ-013 With steps=0, the block SHALL run until stop and SHALL never assert done.
REQ-014 stop=1 in RUN SHALL force IDLE next cycle: busy=0, no done, and no edge in that cycle, even if the timer expires simultaneously.
REQ-015 stop SHALL be ignored in IDLE; if start and stop are both 1 in IDLE, start SHALL be accepted.
REQ-016 signalA/signalB SHALL hold their level in IDLE, and a new run SHALL continue from the current phase without any reset to 00.
REQ-017 edge_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-018 period=1 SHALL produce one edge per CLK cycle, i.e. a full quadrature cycle every 4 CLK cycles.

Reset
REQ-019 Asserting RST at any time, including mid-run, SHALL immediately force IDLE, signalA=0, signalB=0, busy=0, done=0, edge_cnt=0 and timer=0, independent of CLK.
REQ-020 After RST deasserts, the block SHALL accept no start until the first CLK rising edge following deassertion.

Verification
REQ-021 Reset, then start with dir=0, period=3, steps=4 -> (A,B)=10,11,01,00 at cycles 3,6,9,12 after accept; busy=0 and done=1 at cycle 13; edge_cnt=4.
REQ-022 Start with dir=1, period=2, steps=8 -> sequence 01,11,10,00 repeated twice; B=1 at both rising edges of A; a single done pulse.
REQ-023 Start with steps=0, period=1; pulse stop after 10 edges -> edge_cnt=10; busy falls the next cycle; done never asserts; A/B hold their last values.
REQ-024 Pulse start during RUN with different dir/period -> the waveform is unchanged; after completion, a second start continues from the held phase with no extra edge.
REQ-025 Assert RST asynchronously mid-cycle during RUN -> A, B, busy, done and edge_cnt go to 0 without waiting for CLK; the next start begins from phase 00.
REQ-026 Start with period=0, steps=2 -> behaves exactly as period=1: edges at cycles 1 and 2, done at cycle 3.
